// File: rtl/sequencer_scheduler.sv
// Beat divider, cursor/toggle routing and note select for the step sequencer.
// Optional cursor blink on step LEDs: SEQUENCER_SCHEDULER_CURSOR_BLINK_EN.
module sequencer_scheduler #(
   parameter int BASE_TICKS  = 5000,
   parameter int BLINK_TICKS = 2500
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        sequencer_on,
   input  logic        play_pause,
   input  logic        cur_next,
   input  logic        cur_prev,
   input  logic        toggle_in,
   input  logic [1:0]  tempo,
   input  logic [31:0] note_in,
   input  logic [3:0]  piano_note,
   output logic [2:0]  beat,
   output logic        beat_tick,
   output logic [7:0]  toggle_vec,
   output logic [2:0]  cursor,
   output logic [3:0]  note_out,
   output logic [7:0]  step_led
);

   typedef enum logic [1:0] {
      PIANO = 2'd0,
      PAUSE = 2'd1,
      RUN   = 2'd2
   } state_t;

   localparam logic [15:0] BASE = 16'(BASE_TICKS);

   state_t      state;
   state_t      next_state;
   logic [15:0] count;
   logic [15:0] period;
   logic [15:0] last;
   logic        seq_act;
   logic        run_act;
   logic [7:0]  beat_oh;
   logic [7:0]  cur_oh;

   assign period = BASE >> tempo;
   assign last   = period - 16'd1;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= PIANO;
      else        state <= next_state;
   end

   // Dropping sequencer_on wins over every other input
   always_comb begin
      next_state = state;
      if (!sequencer_on) begin
         next_state = PIANO;
      end else begin
         unique case (state)
            PIANO:   next_state = PAUSE;
            PAUSE:   if (play_pause) next_state = RUN;
            RUN:     if (play_pause) next_state = PAUSE;
            default: next_state = PIANO;
         endcase
      end
   end

`ifdef SEQUENCER_SCHEDULER_CURSOR_BLINK_EN
   logic [31:0] blink_cnt;
   logic        blink_phase;

   assign blink_phase = (blink_cnt >= 32'(BLINK_TICKS));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         blink_cnt <= '0;
      else if (state == PIANO)
         blink_cnt <= '0;
      else if (blink_cnt >= 32'(2 * BLINK_TICKS - 1))
         blink_cnt <= '0;
      else
         blink_cnt <= blink_cnt + 32'd1;
   end
`endif

   always_comb begin
      seq_act  = (state != PIANO);
      run_act  = (state == RUN);
      beat_oh  = 8'b1 << beat;
      cur_oh   = 8'b1 << cursor;
      step_led = '0;
      if (seq_act) begin
`ifdef SEQUENCER_SCHEDULER_CURSOR_BLINK_EN
         step_led = beat_oh | (blink_phase ? cur_oh : 8'h00);
`else
         step_led = beat_oh;
`endif
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count     <= '0;
         beat      <= '0;
         beat_tick <= 1'b0;
      end else begin
         beat_tick <= 1'b0;
         if (state == PIANO && sequencer_on) begin
            count <= '0;
            beat  <= '0;
         end else if (run_act) begin
            if (count >= last) begin
               count     <= '0;
               beat      <= beat + 3'd1;
               beat_tick <= 1'b1;
            end else begin
               count <= count + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cursor     <= '0;
         toggle_vec <= '0;
         note_out   <= '0;
      end else begin
         if (seq_act && cur_next && !cur_prev)
            cursor <= cursor + 3'd1;
         else if (seq_act && cur_prev && !cur_next)
            cursor <= cursor - 3'd1;
         toggle_vec <= (seq_act && toggle_in) ? cur_oh : 8'h00;
         note_out   <= seq_act ? note_in[4*beat +: 4] : piano_note;
      end
   end

   logic unused_ok;
   assign unused_ok = ^cur_oh;

endmodule
